spi_echo_slave: RTL and testbench

Parametrised, synthesizable SPI slave responder that replaces the bare `miso = mosi` wire loopback used by the top-level SoC bench. It is clocked by the system clock and oversamples `sclk`, `ss` and `mosi`. It supports all four CPOL/CPHA modes and any frame width, and returns either the previous received frame or a host-loaded word on `miso`. Received frames, a frame counter and abort events are reported so the bench, or an on-chip test harness, can self-check SPI traffic.

---
 rtl/spi_echo_slave_if.sv | 26 ++
 rtl/spi_echo_slave.sv | 158 +++++++++++++++
 tb/tb_spi_echo_slave.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_echo_slave_if.sv
// SPI pin bundle plus the receive/report side-band of the echo slave.
interface spi_echo_slave_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 16
);
    logic                   sclk;
    logic                   ss;
    logic                   mosi;
    logic                   miso;
    logic [DATA_WIDTH-1:0]  txData;
    logic                   txLoad;
    logic [DATA_WIDTH-1:0]  rxData;
    logic                   rxValid;
    logic [COUNT_WIDTH-1:0] frameCount;
    logic                   frameAbort;

    modport slave (
        input  sclk, ss, mosi, txData, txLoad,
        output miso, rxData, rxValid, frameCount, frameAbort
    );

    modport master (
        output sclk, ss, mosi, txData, txLoad,
        input  miso, rxData, rxValid, frameCount, frameAbort
    );
endinterface

// File: rtl/spi_echo_slave.sv
// Oversampling SPI slave that echoes the previous frame (or a loaded word)
// and reports received frames, a frame counter and aborted frames.
module spi_echo_slave #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ECHO_MODE   = 0,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    spi_echo_slave_if.slave bus
);
    localparam int unsigned      CNT_W     = $clog2(DATA_WIDTH);
    localparam logic             CPOL_B    = 1'(CPOL);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   lead_c, trail_c, sample_c, shift_c, ss_fall_c, ss_rise_c;

    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  reply_q, reply_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [COUNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                   frame_abort_q, frame_abort_d;
    logic                   miso_q, miso_d;
    logic                   complete_c;
    logic [DATA_WIDTH-1:0]  frame_c;

    // Input synchronisers plus one extra copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL_B}};
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= CPOL_B;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign lead_c    = (sclk_prev_q == CPOL_B) && (sclk_s != CPOL_B);
    assign trail_c   = (sclk_prev_q != CPOL_B) && (sclk_s == CPOL_B);
    assign sample_c  = (CPHA != 0) ? trail_c : lead_c;
    assign shift_c   = (CPHA != 0) ? lead_c : trail_c;
    assign ss_fall_c = ss_prev_q && !ss_s;
    assign ss_rise_c = !ss_prev_q && ss_s;
    assign frame_c   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        reply_d       = reply_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        frame_abort_d = 1'b0;
        complete_c    = 1'b0;

        // A load strobe coinciding with a shifter load is bypassed via reply_d
        if ((ECHO_MODE != 0) && bus.txLoad) begin
            reply_d = bus.txData;
        end

        case (state_q)
            ST_IDLE: begin
                if (ss_fall_c) begin
                    state_d    = ST_ACTIVE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = reply_d;
                end
            end
            default: begin
                if (sample_c) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        complete_c  = 1'b1;
                        rx_data_d   = frame_c;
                        rx_valid_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + COUNT_WIDTH'(1);
                        if (ECHO_MODE == 0) begin
                            reply_d = frame_c;
                        end
                        bit_cnt_d  = '0;
                        tx_shift_d = reply_d;
                    end else begin
                        rx_shift_d = frame_c;
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_c && (bit_cnt_q != '0)) begin
                    tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                end

                // A completion in the same cycle as ss rising is not an abort
                if (ss_rise_c) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    if (!complete_c && (bit_cnt_q != '0)) begin
                        frame_abort_d = 1'b1;
                    end
                end
            end
        endcase

        miso_d = (state_d == ST_ACTIVE) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            reply_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_cnt_q   <= '0;
            frame_abort_q <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            reply_q       <= reply_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_abort_q <= frame_abort_d;
            miso_q        <= miso_d;
        end
    end

    assign bus.miso       = miso_q;
    assign bus.rxData     = rx_data_q;
    assign bus.rxValid    = rx_valid_q;
    assign bus.frameCount = frame_cnt_q;
    assign bus.frameAbort = frame_abort_q;
endmodule

// File: tb/tb_spi_echo_slave.sv
// Scoreboard bench: three slaves (mode 0 echo, mode 0 loaded reply, mode 3 x16)
// share one bit-banged master; received frames are checked by monitors.
module tb_spi_echo_slave;
    localparam int unsigned H = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk, mosi, ss_a, ss_b, ss_c;
    logic        tx_load_b;
    logic [7:0]  tx_data_b;
    logic        miso_sel;
    logic [15:0] rd;
    int          checks = 0, failures = 0;
    int          aborts_a = 0, valids_a = 0;
    int          abort_base, valid_base, fc;
    logic [7:0]  prev, d;
    logic [31:0] q_a[$], q_b[$], q_c[$];

    always #5 clk = ~clk;

    spi_echo_slave_if #(.DATA_WIDTH(8),  .COUNT_WIDTH(4))  ifa();
    spi_echo_slave_if #(.DATA_WIDTH(8),  .COUNT_WIDTH(16)) ifb();
    spi_echo_slave_if #(.DATA_WIDTH(16), .COUNT_WIDTH(16)) ifc();

    assign ifa.sclk = sclk;  assign ifa.ss = ss_a;  assign ifa.mosi = mosi;
    assign ifa.txData = '0;  assign ifa.txLoad = 1'b0;
    assign ifb.sclk = sclk;  assign ifb.ss = ss_b;  assign ifb.mosi = mosi;
    assign ifb.txData = tx_data_b;  assign ifb.txLoad = tx_load_b;
    assign ifc.sclk = sclk;  assign ifc.ss = ss_c;  assign ifc.mosi = mosi;
    assign ifc.txData = '0;  assign ifc.txLoad = 1'b0;

    assign miso_sel = !ss_a ? ifa.miso : (!ss_b ? ifb.miso : ifc.miso);

    spi_echo_slave #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2),
                     .ECHO_MODE(0), .COUNT_WIDTH(4))
        u_a (.clk(clk), .reset(reset), .bus(ifa));
    spi_echo_slave #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2),
                     .ECHO_MODE(1), .COUNT_WIDTH(16))
        u_b (.clk(clk), .reset(reset), .bus(ifb));
    spi_echo_slave #(.DATA_WIDTH(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(2),
                     .ECHO_MODE(0), .COUNT_WIDTH(16))
        u_c (.clk(clk), .reset(reset), .bus(ifc));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit-banged master: mode 0 (CPOL=0,CPHA=0) or mode 3 (CPOL=1,CPHA=1), MSB first
    task automatic spi_frame(input bit mode3, input int width, input logic [15:0] tx,
                             output logic [15:0] rx);
        rx = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (!mode3) begin
                mosi = tx[i];
                wait_clk(H);
                rx = {rx[14:0], miso_sel};
                sclk = 1'b1;
                wait_clk(H);
                sclk = 1'b0;
            end else begin
                sclk = 1'b0;
                mosi = tx[i];
                wait_clk(H);
                rx = {rx[14:0], miso_sel};
                sclk = 1'b1;
                wait_clk(H);
            end
        end
    endtask

    // Scoreboard monitors: pop the expected {frameCount, rxData} on each rxValid
    always @(negedge clk) begin
        logic [31:0] e;
        if (ifa.rxValid) begin
            valids_a++;
            check("a_rxValid_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("a_frame", {16'(ifa.frameCount), 16'(ifa.rxData)}, e);
            end
        end
        if (ifa.frameAbort) aborts_a++;
        if (ifa.rxValid || ifa.frameAbort)
            check("a_valid_abort_exclusive", 32'(ifa.rxValid & ifa.frameAbort), 32'd0);
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (ifb.rxValid) begin
            check("b_rxValid_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("b_frame", {16'(ifb.frameCount), 16'(ifb.rxData)}, e);
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (ifc.rxValid) begin
            check("c_rxValid_expected", 32'(q_c.size() != 0), 32'd1);
            if (q_c.size() != 0) begin
                e = q_c.pop_front();
                check("c_frame", {16'(ifc.frameCount), 16'(ifc.rxData)}, e);
            end
        end
        if (ifb.frameAbort || ifc.frameAbort)
            check("bc_no_abort", 32'({ifb.frameAbort, ifc.frameAbort}), 32'd0);
    end

    initial begin
        reset = 1'b0; sclk = 1'b0; mosi = 1'b0;
        ss_a = 1'b1; ss_b = 1'b1; ss_c = 1'b1;
        tx_load_b = 1'b0; tx_data_b = '0;
        wait_clk(3);
        check("reset_outputs_a", {16'(ifa.rxData), 4'(ifa.frameCount), 9'd0,
                                  ifa.miso, ifa.rxValid, ifa.frameAbort}, 32'd0);
        check("reset_sclk_idle_c", 32'(ifc.miso), 32'd0);
        reset = 1'b1;
        wait_clk(4);

        // Mode 0 echo: two frames in one ss window
        ss_a = 1'b0; wait_clk(H);
        q_a.push_back({16'd1, 16'h00A5});
        spi_frame(1'b0, 8, 16'h00A5, rd);
        check("a_miso_first", 32'(rd), 32'h0000);
        q_a.push_back({16'd2, 16'h003C});
        spi_frame(1'b0, 8, 16'h003C, rd);
        check("a_miso_second", 32'(rd), 32'h00A5);
        wait_clk(H); ss_a = 1'b1; wait_clk(4 * H);
        check("a_count_two", 32'(ifa.frameCount), 32'd2);

        // Abort after three bits, then a clean frame
        abort_base = aborts_a;
        ss_a = 1'b0; wait_clk(H);
        spi_frame(1'b0, 3, 16'h0005, rd);
        wait_clk(H); ss_a = 1'b1; wait_clk(4 * H);
        check("a_abort_pulse", 32'(aborts_a - abort_base), 32'd1);
        check("a_count_after_abort", 32'(ifa.frameCount), 32'd2);
        check("a_rxdata_after_abort", 32'(ifa.rxData), 32'h003C);
        ss_a = 1'b0; wait_clk(H);
        q_a.push_back({16'd3, 16'h0081});
        spi_frame(1'b0, 8, 16'h0081, rd);
        check("a_miso_after_abort", 32'(rd), 32'h003C);
        wait_clk(H); ss_a = 1'b1; wait_clk(4 * H);

        // Asynchronous reset in the middle of a frame
        ss_a = 1'b0; wait_clk(H);
        spi_frame(1'b0, 3, 16'h0006, rd);
        sclk = 1'b1;
        wait_clk(2);
        #2 reset = 1'b0;
        #1;
        check("midframe_reset_outputs", {16'(ifa.rxData), 4'(ifa.frameCount), 9'd0,
                                         ifa.miso, ifa.rxValid, ifa.frameAbort}, 32'd0);
        ss_a = 1'b1; sclk = 1'b0;
        wait_clk(4);
        reset = 1'b1;
        valid_base = valids_a;
        wait_clk(4 * H);

        // 17 frames after reset on a 4-bit counter: count wraps to 1
        ss_a = 1'b0; wait_clk(H);
        q_a.push_back({16'd1, 16'h003C});
        spi_frame(1'b0, 8, 16'h003C, rd);
        check("a_miso_post_reset", 32'(rd), 32'h0000);
        prev = 8'h3C; fc = 1;
        for (int i = 0; i < 16; i++) begin
            d = 8'((i * 37 + 11) & 255);
            fc = (fc + 1) % 16;
            q_a.push_back({16'(fc), 8'd0, d});
            spi_frame(1'b0, 8, {8'd0, d}, rd);
            if (i % 5 == 0) check("a_miso_wrap", 32'(rd), {24'd0, prev});
            prev = d;
        end
        wait_clk(H); ss_a = 1'b1; wait_clk(4 * H);
        check("a_count_wrap", 32'(ifa.frameCount), 32'd1);
        check("a_valid_pulses", 32'(valids_a - valid_base), 32'd17);

        // Loaded reply word
        tx_data_b = 8'h5A; tx_load_b = 1'b1;
        wait_clk(1);
        tx_load_b = 1'b0; tx_data_b = 8'h00;
        ss_b = 1'b0; wait_clk(H);
        q_b.push_back({16'd1, 16'h00FF});
        spi_frame(1'b0, 8, 16'h00FF, rd);
        check("b_miso_loaded", 32'(rd), 32'h005A);
        q_b.push_back({16'd2, 16'h000F});
        spi_frame(1'b0, 8, 16'h000F, rd);
        check("b_miso_held", 32'(rd), 32'h005A);
        wait_clk(H); ss_b = 1'b1; wait_clk(4 * H);

        // Mode 3, 16-bit frames
        sclk = 1'b1; wait_clk(4 * H);
        ss_c = 1'b0; wait_clk(H);
        q_c.push_back({16'd1, 16'hC3E1});
        spi_frame(1'b1, 16, 16'hC3E1, rd);
        check("c_miso_first", 32'(rd), 32'h0000);
        q_c.push_back({16'd2, 16'h1234});
        spi_frame(1'b1, 16, 16'h1234, rd);
        check("c_miso_second", 32'(rd), 32'hC3E1);
        wait_clk(H); ss_c = 1'b1; wait_clk(4 * H);
        check("c_miso_idle", 32'(ifc.miso), 32'd0);

        for (int k = 0; k < 200 && (q_a.size() + q_b.size() + q_c.size()) != 0; k++)
            wait_clk(1);
        check("scoreboard_drained", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
        check("a_total_aborts", 32'(aborts_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
